// File: rtl/spi_receiver.sv
// SPI slave byte receiver: synchronises spi_clk/spi_data into clk, assembles
// MSB-first bytes and hands them out over a valid/ready register with overrun and timeout flags.
module spi_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDLE_W = 16;

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic                r_sdat_s1, r_sdat_s2;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [7:0]          r_shift;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic                w_rise;
  logic                w_byte_done;
  logic                w_timeout;
  logic                w_accept;
  logic [7:0]          w_byte;

  // spi_clk resets high so releasing rst with an idle bus yields no edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s1 <= 1'b1;
      r_sclk_s2 <= 1'b1;
      r_sclk_s3 <= 1'b1;
      r_sdat_s1 <= 1'b0;
      r_sdat_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_clk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_sdat_s1 <= spi_data;
      r_sdat_s2 <= r_sdat_s1;
    end
  end

  assign w_rise      = r_sclk_s2 & ~r_sclk_s3;
  assign w_byte_done = w_rise && (r_bit_cnt == CNT_W'(7));
  assign w_timeout   = (r_state == RECV) && !w_rise &&
                       (r_idle_cnt >= IDLE_W'(TIMEOUT_CYCLES));
  assign w_accept    = data_valid & data_ready;
  assign w_byte      = {r_shift[6:0], r_sdat_s2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_state_nxt = RECV;
      RECV:    if (w_byte_done || w_timeout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit assembly and inactivity timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_idle_cnt  <= '0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (w_timeout)   r_bit_cnt <= '0;
      else if (w_rise) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      if (w_rise) r_shift <= w_byte;
      if ((r_state == RECV) && !w_rise && !w_timeout)
        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      else
        r_idle_cnt <= '0;
      frame_error <= w_timeout;
      busy        <= (w_state_nxt == RECV);
    end
  end

  // Output holding register: a completed byte loads only if the slot is free or being freed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (w_byte_done && (!data_valid || w_accept)) begin
        data_out   <= w_byte;
        data_valid <= 1'b1;
      end else if (w_accept) begin
        data_valid <= 1'b0;
      end
      if (w_byte_done && data_valid && !w_accept) overrun <= 1'b1;
      else if (overrun_clr)                        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_receiver.sv
// Bench for spi_receiver: table of two-byte transfers, hand sequences for
// latency/timeout/reset corners, and a randomized stream checked against an expected-byte queue.
`timescale 1ns/1ps
module tb_spi_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b1;
  logic       spi_data = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       overrun;
  logic       overrun_clr = 1'b0;
  logic       frame_error;
  logic       busy;

  int checks = 0;
  int errors = 0;

  spi_receiver #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_data(spi_data),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Observer: accepted bytes, pulse counts and hold-stability violations
  logic [7:0] acc_log [0:255];
  int acc_cnt = 0, fe_cnt = 0, fe_long = 0, valid_cycles = 0, busy_cycles = 0;
  int stab_viol = 0, vfall = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_fe = 1'b0;
  logic [7:0] prev_out = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_v  <= 1'b0;
      prev_fe <= 1'b0;
    end else begin
      if (data_valid && data_ready) begin
        acc_log[acc_cnt[7:0]] <= data_out;
        acc_cnt <= acc_cnt + 1;
      end
      if (frame_error) fe_cnt <= fe_cnt + 1;
      if (frame_error && prev_fe) fe_long <= fe_long + 1;
      if (data_valid) valid_cycles <= valid_cycles + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (prev_v && !prev_r && (!data_valid || data_out !== prev_out))
        stab_viol <= stab_viol + 1;
      if (prev_v && !data_valid) vfall <= vfall + 1;
      prev_v   <= data_valid;
      prev_r   <= data_ready;
      prev_out <= data_out;
      prev_fe  <= frame_error;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bit(input logic b);
    spi_clk  = 1'b0;
    spi_data = b;
    tick(5);
    spi_clk = 1'b1;
    tick(5);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    spi_clk = 1'b1;
    spi_data = 1'b0;
    data_ready = 1'b0;
    overrun_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       rdy;
    logic [7:0] exp_out;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_acc;
  } vec_t;

  vec_t vecs [5];
  logic [7:0] exp_q [$];

  initial begin
    int base_acc, base_fe, base_fel, base_v, base_b, base_st, base_vf, exp_fe;
    logic [7:0] b;

    vecs[0] = '{b0: 8'h3C, b1: 8'hC3, rdy: 1'b0, exp_out: 8'h3C, exp_valid: 1'b1, exp_ovr: 1'b1, exp_acc: 0};
    vecs[1] = '{b0: 8'hA5, b1: 8'h5A, rdy: 1'b1, exp_out: 8'h5A, exp_valid: 1'b0, exp_ovr: 1'b0, exp_acc: 2};
    vecs[2] = '{b0: 8'h00, b1: 8'hFF, rdy: 1'b1, exp_out: 8'hFF, exp_valid: 1'b0, exp_ovr: 1'b0, exp_acc: 2};
    vecs[3] = '{b0: 8'hFF, b1: 8'h00, rdy: 1'b0, exp_out: 8'hFF, exp_valid: 1'b1, exp_ovr: 1'b1, exp_acc: 0};
    vecs[4] = '{b0: 8'h01, b1: 8'h80, rdy: 1'b1, exp_out: 8'h80, exp_valid: 1'b0, exp_ovr: 1'b0, exp_acc: 2};

    // Reset values, sampled while rst is held
    tick(2);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_frame_error", 32'(frame_error), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // 0xA5 with ready high: busy over edges 1..7, one-cycle valid three cycles after edge 8
    do_reset();
    data_ready = 1'b1;
    base_acc = acc_cnt;
    base_v = valid_cycles;
    chk("a5_busy_before", 32'(busy), 32'h0);
    for (int i = 7; i >= 1; i--) begin
      spi_bit(8'hA5 >> i);
      chk("a5_busy_mid", 32'(busy), 32'h1);
    end
    spi_clk = 1'b0;
    spi_data = 1'b1;
    tick(5);
    spi_clk = 1'b1;
    repeat (3) @(negedge clk);
    chk("a5_valid_not_early", 32'(data_valid), 32'h0);
    @(negedge clk);
    chk("a5_valid", 32'(data_valid), 32'h1);
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_busy_after", 32'(busy), 32'h0);
    @(negedge clk);
    chk("a5_valid_drop", 32'(data_valid), 32'h0);
    @(posedge clk);
    #1;
    tick(2);
    chk("a5_valid_cycles", 32'(valid_cycles - base_v), 32'd1);
    chk("a5_accepts", 32'(acc_cnt - base_acc), 32'd1);
    chk("a5_logged", 32'(acc_log[base_acc[7:0]]), 32'hA5);

    // Table: two back-to-back bytes with data_ready held constant
    foreach (vecs[k]) begin
      do_reset();
      data_ready = vecs[k].rdy;
      base_acc = acc_cnt;
      base_st = stab_viol;
      send_byte(vecs[k].b0);
      send_byte(vecs[k].b1);
      tick(5);
      data_ready = 1'b0;
      tick(1);
      chk($sformatf("vec%0d_data", k), 32'(data_out), 32'(vecs[k].exp_out));
      chk($sformatf("vec%0d_valid", k), 32'(data_valid), 32'(vecs[k].exp_valid));
      chk($sformatf("vec%0d_overrun", k), 32'(overrun), 32'(vecs[k].exp_ovr));
      chk($sformatf("vec%0d_accepts", k), 32'(acc_cnt - base_acc), 32'(vecs[k].exp_acc));
      chk($sformatf("vec%0d_hold", k), 32'(stab_viol - base_st), 32'd0);
      if (vecs[k].exp_acc == 2) begin
        chk($sformatf("vec%0d_first", k), 32'(acc_log[base_acc[7:0]]), 32'(vecs[k].b0));
        chk($sformatf("vec%0d_second", k), 32'(acc_log[8'(base_acc + 1)]), 32'(vecs[k].b1));
      end
      if (vecs[k].exp_ovr) begin
        tick(3);
        chk($sformatf("vec%0d_overrun_sticky", k), 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        tick(1);
        chk($sformatf("vec%0d_overrun_clr", k), 32'(overrun), 32'h0);
        chk($sformatf("vec%0d_valid_after_clr", k), 32'(data_valid), 32'h1);
      end
    end

    // 0x81 held, 0x7E completes in the very cycle 0x81 is accepted: no valid gap
    do_reset();
    base_acc = acc_cnt;
    base_vf = vfall;
    base_st = stab_viol;
    send_byte(8'h81);
    for (int i = 7; i >= 1; i--) spi_bit(8'h7E >> i);
    spi_clk = 1'b0;
    spi_data = 1'b0;
    tick(5);
    spi_clk = 1'b1;
    tick(2);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    tick(3);
    chk("swap_valid", 32'(data_valid), 32'h1);
    chk("swap_data", 32'(data_out), 32'h7E);
    chk("swap_overrun", 32'(overrun), 32'h0);
    chk("swap_accepts", 32'(acc_cnt - base_acc), 32'd1);
    chk("swap_first", 32'(acc_log[base_acc[7:0]]), 32'h81);
    chk("swap_no_gap", 32'(vfall - base_vf), 32'd0);
    chk("swap_hold", 32'(stab_viol - base_st), 32'd0);

    // Three bits then silence: single frame_error after the timeout, then a clean byte
    do_reset();
    data_ready = 1'b1;
    base_fe = fe_cnt;
    base_fel = fe_long;
    base_acc = acc_cnt;
    spi_bit(1'b1);
    spi_bit(1'b0);
    spi_bit(1'b1);
    tick(40);
    chk("to_busy_pending", 32'(busy), 32'h1);
    chk("to_no_early_fe", 32'(fe_cnt - base_fe), 32'd0);
    tick(60);
    chk("to_fe_count", 32'(fe_cnt - base_fe), 32'd1);
    chk("to_fe_one_cycle", 32'(fe_long - base_fel), 32'd0);
    chk("to_busy_clear", 32'(busy), 32'h0);
    chk("to_no_valid", 32'(data_valid), 32'h0);
    send_byte(8'h55);
    tick(5);
    chk("to_next_accepts", 32'(acc_cnt - base_acc), 32'd1);
    chk("to_next_data", 32'(acc_log[base_acc[7:0]]), 32'h55);

    // Reset after five bits discards the partial byte
    do_reset();
    for (int i = 7; i >= 3; i--) spi_bit(8'hAB >> i);
    rst = 1'b1;
    tick(2);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_valid", 32'(data_valid), 32'h0);
    rst = 1'b0;
    base_fe = fe_cnt;
    base_v = valid_cycles;
    tick(80);
    chk("mid_rst_no_fe", 32'(fe_cnt - base_fe), 32'd0);
    chk("mid_rst_no_valid", 32'(valid_cycles - base_v), 32'd0);
    chk("mid_rst_no_overrun", 32'(overrun), 32'h0);
    send_byte(8'hF0);
    tick(5);
    chk("mid_rst_next_valid", 32'(data_valid), 32'h1);
    chk("mid_rst_next_data", 32'(data_out), 32'hF0);
    chk("mid_rst_next_overrun", 32'(overrun), 32'h0);

    // Release reset with spi_clk idle high: nothing happens
    rst = 1'b1;
    spi_clk = 1'b1;
    tick(2);
    rst = 1'b0;
    base_b = busy_cycles;
    base_v = valid_cycles;
    base_fe = fe_cnt;
    tick(100);
    chk("idle_busy", 32'(busy_cycles - base_b), 32'd0);
    chk("idle_valid", 32'(valid_cycles - base_v), 32'd0);
    chk("idle_fe", 32'(fe_cnt - base_fe), 32'd0);

    // Random stream with occasional aborted fragments; model keeps only whole bytes
    do_reset();
    data_ready = 1'b1;
    base_acc = acc_cnt;
    base_fe = fe_cnt;
    exp_fe = 0;
    exp_q.delete();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 7)); j++) spi_bit(1'($urandom));
        tick(90);
        exp_fe++;
      end
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b);
      tick(int'($urandom_range(0, 12)));
    end
    tick(10);
    chk("rand_accepts", 32'(acc_cnt - base_acc), 32'(exp_q.size()));
    chk("rand_frame_errors", 32'(fe_cnt - base_fe), 32'(exp_fe));
    chk("rand_overrun", 32'(overrun), 32'h0);
    foreach (exp_q[i])
      chk($sformatf("rand_byte%0d", i), 32'(acc_log[8'(base_acc + i)]), 32'(exp_q[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_receiver.md
SPI_RECEIVER -- requirements
Module: spi_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning clk cycles without an spi_clk rising edge that abort a partial byte (legal range 16..65535).
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz nominal.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port spi_clk  input  1  serial clock, asynchronous to clk, idle high, max frequency clk/8.
REQ-005 SHALL have port spi_data  input  1  serial data, MSB first, changes on spi_clk falling edge.
REQ-006 SHALL have port data_out  output  8  last received byte.
REQ-007 SHALL have port data_valid  output  1  data_out holds an unconsumed byte.
REQ-008 SHALL have port data_ready  input  1  consumer accepts data_out this cycle.
REQ-009 SHALL have port overrun  output  1  sticky: a completed byte was dropped.
REQ-010 SHALL have port overrun_clr  input  1  clears overrun.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse: partial byte aborted by timeout.
REQ-012 SHALL have port busy  output  1  high while 1..7 bits of a byte are held.

Function
REQ-013 SHALL pass spi_clk and spi_data each through a 2-flop synchronizer in clk; spi_clk chain gets a third flop for edge detection.
REQ-014 SHALL detect a rising edge when synchronized spi_clk stage 2 = 1 and stage 3 = 0; SHALL sample spi_data from its stage 2 in that same cycle.
REQ-015 SHALL ignore spi_clk falling edges.
REQ-016 SHALL shift sampled bits into an 8-bit shift register MSB first, with a 3-bit bit counter.
REQ-017 SHALL use two states: IDLE (bit counter 0, busy 0) and RECV (1..7 bits held, busy 1).
REQ-018 IDLE -> RECV on a rising edge; RECV stays on edges 2..7; on edge 8 the byte completes and state returns to IDLE with bit counter 0.
REQ-019 On byte completion SHALL load data_out and assert data_valid in the next clk cycle (1 cycle after the detecting cycle).
REQ-020 data_valid SHALL stay high and data_out stable until a cycle with data_valid=1 and data_ready=1; data_valid drops the following cycle.
REQ-021 data_ready while data_valid=0 SHALL have no effect.
REQ-022 If a byte completes in the same cycle as an accept, the new byte SHALL load and data_valid SHALL stay 1 (no gap).
REQ-023 If a byte completes while data_valid=1 and no accept that cycle, the new byte SHALL be dropped, data_out retained, overrun set.
REQ-024 overrun SHALL stay 1 until overrun_clr=1; set and clear in the same cycle -> overrun ends 1 (set wins).
REQ-025 In RECV a 16-bit idle counter SHALL count clk cycles since the last rising edge and reset to 0 on every edge.
REQ-026 When the idle counter reaches TIMEOUT_CYCLES in RECV, SHALL pulse frame_error for one cycle, discard the partial byte, clear bit counter, return to IDLE; data_out/data_valid unaffected.
REQ-027 Idle counter SHALL hold at 0 in IDLE; no timeout in IDLE.
REQ-028 Back-to-back bytes with no gap SHALL be received without loss provided the consumer accepts each within 8 spi_clk periods.

Reset
REQ-029 On rst: data_out=0x00, data_valid=0, overrun=0, frame_error=0, busy=0, state IDLE, bit and idle counters 0.
REQ-030 On rst: spi_clk synchronizer flops SHALL reset to 1 and spi_data flops to 0, so reset release with spi_clk idle high produces no false edge.
REQ-031 rst asserted mid-byte SHALL abort the byte immediately with no data_valid, frame_error or overrun afterwards.

Verification
REQ-032 Send 0xA5 at spi_clk = clk/10, data_ready=1 -> data_valid one cycle, data_out=0xA5, busy high from edge 1 to edge 8.
REQ-033 Send 0x3C then 0xC3 back-to-back, data_ready=0 -> data_out=0x3C, overrun=1 after byte 2; pulse overrun_clr -> overrun=0.
REQ-034 Send 0x81, hold data_ready=0, send 0x7E with data_ready=1 exactly at byte 2 completion -> data_valid continuous, data_out=0x7E, overrun=0.
REQ-035 Send 3 bits then hold spi_clk high for 64 clk cycles -> frame_error one pulse, busy=0; following byte 0x55 received as 0x55.
REQ-036 Assert rst after 5 bits, release, send 0xF0 -> no output for the partial byte, data_out=0xF0.
REQ-037 Release rst with spi_clk held high for 100 cycles -> busy=0, data_valid=0, frame_error=0 throughout.
